// File: rtl/facc_pkg.sv
// facc_pkg: FSM encodings, binary32 field constants and a leading-zero helper
// shared by the facc accumulator and its fadd datapath.
`default_nettype none

package facc_pkg;

  localparam logic [1:0] FACC_IDLE = 2'd0;
  localparam logic [1:0] FACC_ACC  = 2'd1;
  localparam logic [1:0] FACC_DONE = 2'd2;

  localparam int         FP_EXP_MSB  = 30;
  localparam int         FP_EXP_LSB  = 23;
  localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;

  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/facc_fadd.sv
// fadd: combinational binary32 adder, round-to-nearest-even, subnormal aware.
// Revision: 1.0
`default_nettype none

module fadd
  import facc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [31:0] w_big, w_sml;
  logic [7:0]  w_eb, w_es, w_diff, w_shl;
  logic [4:0]  w_sh, w_lz;
  logic [49:0] w_sw;
  logic [26:0] w_al_big, w_al_sml, w_norm;
  logic [27:0] w_sum;
  logic [24:0] w_mr;
  logic [23:0] w_mant;
  logic [9:0]  w_en, w_ef;
  logic        w_sub, w_rup, w_sign;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;

  always_comb begin
    // Order operands by magnitude so the aligned subtraction never goes negative.
    w_big    = (a[30:0] >= b[30:0]) ? a : b;
    w_sml    = (a[30:0] >= b[30:0]) ? b : a;
    w_eb     = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es     = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_diff   = w_eb - w_es;
    w_sh     = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];
    w_sw     = {(w_sml[30:23] != 8'd0), w_sml[22:0], 26'd0} >> w_sh;
    w_al_sml = {w_sw[49:24], |w_sw[23:0]};
    w_al_big = {(w_big[30:23] != 8'd0), w_big[22:0], 3'd0};
    w_sub    = w_big[31] ^ w_sml[31];
    w_sum    = w_sub ? ({1'b0, w_al_big} - {1'b0, w_al_sml})
                     : ({1'b0, w_al_big} + {1'b0, w_al_sml});
    w_lz     = clz27(w_sum[26:0]);
    w_shl    = 8'd0;
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_en   = {2'b00, w_eb} + 10'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results land as subnormals.
      w_shl  = ({3'b000, w_lz} < w_eb) ? {3'b000, w_lz} : (w_eb - 8'd1);
      w_norm = w_sum[26:0] << w_shl;
      w_en   = {2'b00, w_eb} - {2'b00, w_shl};
    end
    w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mr  = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
    if (w_mr[24]) begin
      w_mant = w_mr[24:1];
      w_ef   = w_en + 10'd1;
    end else begin
      w_mant = w_mr[23:0];
      w_ef   = w_en;
    end
    w_sign  = (w_sum == 28'd0) ? (~w_sub & w_big[31]) : w_big[31];
    w_nan_a = (a[30:23] == FP_EXP_ALL1) && (a[22:0] != 23'd0);
    w_nan_b = (b[30:23] == FP_EXP_ALL1) && (b[22:0] != 23'd0);
    w_inf_a = (a[30:23] == FP_EXP_ALL1) && (a[22:0] == 23'd0);
    w_inf_b = (b[30:23] == FP_EXP_ALL1) && (b[22:0] == 23'd0);

    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (a[31] ^ b[31])))
      y = 32'h7FC0_0000;
    else if (w_inf_a)
      y = a;
    else if (w_inf_b)
      y = b;
    else if (w_ef >= 10'd255)
      y = {w_sign, FP_EXP_ALL1, 23'd0};
    else
      y = {w_sign, (w_mant[23] ? w_ef[7:0] : 8'd0), w_mant[22:0]};
  end

endmodule

`default_nettype wire

// File: rtl/facc.sv
// facc: streaming binary32 packet accumulator around a combinational fadd.
// Optional sticky inf/NaN flag on out_inf when FACC_INF_FLAG_EN is defined. Revision: 1.0
`default_nettype none

module facc
  import facc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_inf
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [1:0]       r_state, w_next;
  logic [31:0]      r_acc, w_sum, w_acc_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             w_accept, w_result_hs;

  fadd u_fadd (
    .a (r_acc),
    .b (in_data),
    .y (w_sum)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_result_hs = out_valid && out_ready;
  // First beat of a packet is loaded as-is rather than added to zero.
  assign w_acc_d     = (r_state == FACC_IDLE) ? in_data : w_sum;
  assign w_cnt_inc   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FACC_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FACC_IDLE: if (w_accept) w_next = in_last ? FACC_DONE : FACC_ACC;
      FACC_ACC:  if (w_accept && in_last) w_next = FACC_DONE;
      FACC_DONE: if (out_ready) w_next = FACC_IDLE;
      default:   w_next = FACC_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != FACC_DONE);
    out_valid = (r_state == FACC_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 32'd0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_d;
      r_cnt <= (r_state == FACC_IDLE) ? CNT_W'(1) : w_cnt_inc;
    end else if (w_result_hs) begin
      r_acc <= 32'd0;
      r_cnt <= '0;
    end
  end

  assign out_data  = r_acc;
  assign out_count = r_cnt;

`ifdef FACC_INF_FLAG_EN
  logic r_inf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_inf <= 1'b0;
    else if (w_result_hs)
      r_inf <= 1'b0;
    else if (w_accept && (w_acc_d[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL1))
      r_inf <= 1'b1;
  end

  assign out_inf = r_inf;
`else
  assign out_inf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_facc.sv
// tb_facc: directed scoreboard bench for facc (CNT_W=2 so saturation is reachable).
`default_nettype none

module tb_facc;

  localparam int CNT_W = 2;
`ifdef FACC_INF_FLAG_EN
  localparam logic EXP_INF = 1'b1;
`else
  localparam logic EXP_INF = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [31:0] count;
    logic        inf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last, out_valid, out_ready, out_inf;
  logic [31:0]      in_data, out_data;
  logic [CNT_W-1:0] out_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  facc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_inf   (out_inf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] c, input logic f);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.inf   = f;
    sb.push_back(e);
  endtask

  // Drive one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic last);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n        = 0;
    ok       = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %h not accepted within 20 cycles", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: compares every presented result against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h count %0d, expected none", out_data, out_count);
      end else begin
        chk("out_data", out_data, sb[0].data);
        chk("out_count", 32'(out_count), sb[0].count);
        chk("out_inf", {31'd0, out_inf}, {31'd0, sb[0].inf});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_inf", {31'd0, out_inf}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-beat packet, result valid for exactly one cycle.
    push(32'h4A06_DAE0, 32'd2, 1'b0);
    send(32'h4A36_00CA, 1'b0);
    send(32'hC93C_97A8, 1'b1);
    chk("two_beat_valid_hi", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("two_beat_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("two_beat_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-beat packet loads directly.
    push(32'h3F80_0000, 32'd1, 1'b0);
    send(32'h3F80_0000, 1'b1);
    @(posedge clk);
    #1;

    // Backpressure with a beat offered during the stall.
    out_ready = 1'b0;
    push(32'h482B_C276, 32'd2, 1'b0);
    send(32'h4894_B8F8, 1'b0);
    send(32'hC7FB_5EF5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h4000_0000;
      in_last  = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("after_hs_count", 32'(out_count), 32'd0);
    chk("after_hs_data", out_data, 32'd0);

    // Saturation: 1+2+3+4+5 = 15.0, count clamps at 3.
    push(32'h4170_0000, 32'd3, 1'b0);
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b0);
    send(32'h4080_0000, 1'b0);
    send(32'h40A0_0000, 1'b1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-packet discards the partial sum.
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    push(32'h4AD7_D081, 32'd2, 1'b0);
    send(32'h4AA4_6873, 1'b0);
    send(32'h49CD_A038, 1'b1);
    @(posedge clk);
    #1;

    // Overflow to infinity exercises the sticky flag.
    push(32'h7F80_0000, 32'd2, EXP_INF);
    send(32'h7F00_0000, 1'b0);
    send(32'h7F00_0000, 1'b1);
    @(posedge clk);
    #1;
    chk("inf_cleared", {31'd0, out_inf}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/facc.md
# facc

Streaming single-precision floating-point accumulator. Accepts a packet of IEEE-754 binary32 operands over a valid/ready input stream, sums them sequentially through one combinational `fadd` instance, and presents the packet total on a valid/ready output. Sits directly downstream of the operand source and wraps `fadd` as its datapath, turning the single-shot adder into a packet-reduction stage.

## Interface
- `CNT_W`, default 16: width of the element counter.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand beat present.
- `in_ready`  output  1  stage can accept a beat.
- `in_data`  input  32  binary32 operand.
- `in_last`  input  1  final beat of the packet; qualified by `in_valid`.
- `out_valid`  output  1  packet sum available.
- `out_ready`  input  1  consumer accepts the sum.
- `out_data`  output  32  binary32 packet sum.
- `out_count`  output  CNT_W  number of beats in the packet, saturating.
- `out_inf`  output  1  sticky inf/NaN flag; see Configuration.

## Operation
- FSM states are IDLE, ACC and DONE. Reset state is IDLE.
- A beat is accepted on a rising edge with `in_valid && in_ready`. `in_ready` = (state != DONE).
- IDLE, beat accepted: `acc <= in_data` (loaded directly, with no add against zero), `cnt <= 1`. If `in_last` is set, go to DONE. Otherwise go to ACC.
- ACC, beat accepted: `acc <= fadd(acc, in_data)`, `cnt <= sat(cnt+1)`. If `in_last` is set, go to DONE.
- DONE: `out_valid`=1. `out_data`=acc and `out_count`=cnt are held stable. When `out_ready` is seen, go to IDLE and clear `acc` and `cnt` to 0.
- Counter saturates at 2^CNT_W−1 and never wraps. The sum continues to accumulate after saturation.
- No rounding or normalisation is done in this block. Arithmetic semantics are exactly those of `fadd`.
- Beats are not accepted in DONE, so a new packet cannot overlap the pending result.
- Reset asserted mid-packet discards the partial sum with no output, and returns the FSM to IDLE.

## Timing
- Reset values: `in_ready`=1 and `out_valid`=0. `out_data`, `out_count` and `out_inf` are all 0.
- Throughput is one beat per cycle in IDLE/ACC. The `fadd` path is acc register to acc register in a single cycle.
- Latency: when the `in_last` beat is accepted at edge N, `out_valid` is high after edge N.
- The result is accepted at the first edge where `out_valid && out_ready`. `in_ready` rises after that edge. The earliest next beat is accepted one cycle after the result handshake.
- `in_ready` has no combinational dependence on `out_ready`. All outputs are registered or decoded from state only.
- An `in_valid` in DONE is ignored and stalled by `in_ready`=0. The source must hold `in_data`/`in_last` until accepted.

## Configuration
- `FACC_INF_FLAG_EN` defined: a sticky flag register is set whenever the value written to `acc` has exponent field 8'hFF. `out_inf` shows this flag. The flag clears on the result handshake and on reset.
- `FACC_INF_FLAG_EN` undefined: there is no flag register and `out_inf` is tied to 0.

## Structure
- The shared header/package holds the FSM state encodings (`FACC_IDLE`, `FACC_ACC`, `FACC_DONE`, 2 bits) and the binary32 field constants (`FP_EXP_MSB`/`LSB` and `FP_EXP_ALL1` = 8'hFF).
- One sub-module, `fadd`, is used unmodified as a combinational instance: a = acc, b = in_data.
- Expected RTL size is about 150 lines.

## Test plan
- Two-beat packet: 4A36_00CA, then C93C_97A8 with `in_last`, and `out_ready`=1. Required: `out_data`=4A06_DAE0, `out_count`=2, and `out_valid` high for exactly 1 cycle.
- Single-beat packet: 3F80_0000 with `in_last`. Required: `out_data`=3F80_0000 (loaded directly, no add) and `out_count`=1.
- Backpressure: two-beat packet 4894_B8F8 then C7FB_5EF5, with `out_ready` held low 3 cycles. Required: `out_data`=482B_C276 held stable, `in_ready`=0 throughout, and a beat offered during the stall is not consumed.
- Saturation with CNT_W=2: a 5-beat packet. Required: `out_count`=3, and `out_data` matches a bench model that chains `fadd`.
- Reset mid-packet: after 2 beats, pulse `rst` asynchronously. Required: `out_valid`=0 and `in_ready`=1 immediately. A following packet 4AA4_6873 + 49CD_A038 gives 4AD7_D081.
- Flag (macro defined): 7F00_0000 + 7F00_0000. Required: `out_inf`=1, which clears after the handshake. With the macro undefined, `out_inf` stays 0.
